// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the register-bank slave FSM state type.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

endpackage

// File: rtl/ahblite_byte_strobe.sv
// Decodes HSIZE and HADDR[1:0] into little-endian byte-lane strobes and a misalignment flag.
module ahblite_byte_strobe
    import ahblite_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       misalign
);

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb     = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahblite_regbank_slave.sv
// AHB-Lite slave exposing NREG 32-bit registers with a two-cycle ERROR response.
// Wait states are inserted only when AHBLITE_REGBANK_WAIT_EN is defined.
module ahblite_regbank_slave
    import ahblite_pkg::*;
#(
    parameter int NREG        = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic                 HWRITE,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [32*NREG-1:0]   REG_Q
);

    localparam int IDX_W = $clog2(NREG);

    state_e              state_q, state_d;
    logic                dphase_q, dphase_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          strb_q, strb_d;
    logic [32*NREG-1:0]  regs_q, regs_d;

`ifdef AHBLITE_REGBANK_WAIT_EN
    logic [3:0]          cnt_q, cnt_d;
`else
    logic [3:0]          wait_cycles_unused;
    assign wait_cycles_unused = WAIT_CYCLES[3:0];
`endif

    logic       hreadyout;
    logic       hresp;
    logic       trans_active;
    logic       accept;
    logic       xfer_err;
    logic       dphase_done;
    logic [3:0] strb;
    logic       misalign;

    ahblite_byte_strobe u_strobe (
        .hsize    (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .strb     (strb),
        .misalign (misalign)
    );

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase

        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase

        // Gating with our own ready keeps WAIT/ERR1 deaf even if the bus mux misbehaves.
        accept      = HSEL && trans_active && HREADY && hreadyout;
        xfer_err    = (HADDR[31:2] >= 30'(NREG)) || (HSIZE > HSIZE_WORD) || misalign;
        dphase_done = dphase_q && hreadyout;
    end

    always_comb begin
        state_d  = state_q;
        dphase_d = dphase_q && !hreadyout;
        write_d  = write_q;
        idx_d    = idx_q;
        strb_d   = strb_q;
`ifdef AHBLITE_REGBANK_WAIT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
`ifdef AHBLITE_REGBANK_WAIT_EN
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (xfer_err) begin
                state_d  = ST_ERR1;
                dphase_d = 1'b0;
            end else begin
                dphase_d = 1'b1;
                write_d  = HWRITE;
                idx_d    = HADDR[IDX_W+1:2];
                strb_d   = strb;
`ifdef AHBLITE_REGBANK_WAIT_EN
                if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
`endif
            end
        end
    end

    // Writes land only on the completing cycle, so a reset during wait states drops them.
    always_comb begin
        regs_d = regs_q;
        if (dphase_done && write_q) begin
            for (int k = 0; k < NREG; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((idx_q == IDX_W'(k)) && strb_q[b]) begin
                        regs_d[32*k + 8*b +: 8] = HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            strb_q   <= '0;
            regs_q   <= '0;
`ifdef AHBLITE_REGBANK_WAIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dphase_q <= dphase_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            strb_q   <= strb_d;
            regs_q   <= regs_d;
`ifdef AHBLITE_REGBANK_WAIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign HREADYOUT = hreadyout;
    assign HRESP     = hresp;
    assign HRDATA    = (dphase_done && !write_q) ? regs_q[{idx_q, 5'd0} +: 32] : 32'd0;
    assign REG_Q     = regs_q;

endmodule

// File: tb/tb_ahblite_regbank_slave.sv
// Directed bench for ahblite_regbank_slave (NREG=8, WAIT_CYCLES=2); follows AHBLITE_REGBANK_WAIT_EN.
module tb_ahblite_regbank_slave;

`ifdef AHBLITE_REGBANK_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         HSEL;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [2:0]   HSIZE;
    logic         HWRITE;
    logic [31:0]  HWDATA;
    logic         HREADY;
    logic         HREADYOUT;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [255:0] REG_Q;

    logic [255:0] exp_regs;
    int           cmp_cnt = 0;
    int           fail_cnt = 0;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahblite_regbank_slave #(.NREG(8), .WAIT_CYCLES(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .REG_Q     (REG_Q)
    );

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = 32'd0;
        HSIZE  = 3'd2;
        HWRITE = 1'b0;
    endtask

    // Single transfer; returns at the negedge of the last data-phase cycle.
    task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int nwait, output logic err);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = sz; HWRITE = wr;
        @(negedge HCLK);
        bus_idle();
        HWDATA = wd;
        nwait = 0;
        err   = 1'b0;
        while (HREADYOUT !== 1'b1 && nwait < 40) begin
            if (HRESP === 1'b1) err = 1'b1;
            nwait++;
            @(negedge HCLK);
        end
        if (HRESP === 1'b1) err = 1'b1;
        rd = HRDATA;
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        cmp_cnt++;
        if (HREADYOUT !== 1'b1) begin fail_cnt++; $display("FAIL rst_hreadyout got=%b want=1", HREADYOUT); end
        cmp_cnt++;
        if (HRESP !== 1'b0) begin fail_cnt++; $display("FAIL rst_hresp got=%b want=0", HRESP); end
        cmp_cnt++;
        if (HRDATA !== 32'd0) begin fail_cnt++; $display("FAIL rst_hrdata got=%h want=0", HRDATA); end
        cmp_cnt++;
        if (REG_Q !== 256'd0) begin fail_cnt++; $display("FAIL rst_regq got=%h want=0", REG_Q); end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        int          nw;
        logic        er;
        xfer(32'h04, 3'd2, 1'b1, 32'hDEADBEEF, rd, nw, er);
        exp_regs[63:32] = 32'hDEADBEEF;
        cmp_cnt++;
        if (nw != EXP_WAIT || er) begin fail_cnt++; $display("FAIL word_wr_waits got=%0d err=%b want=%0d err=0", nw, er, EXP_WAIT); end
        xfer(32'h04, 3'd2, 1'b0, 32'h0, rd, nw, er);
        cmp_cnt++;
        if (REG_Q[63:32] !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL word_regq got=%h want=deadbeef", REG_Q[63:32]); end
        cmp_cnt++;
        if (nw != EXP_WAIT) begin fail_cnt++; $display("FAIL word_rd_waits got=%0d want=%0d", nw, EXP_WAIT); end
        cmp_cnt++;
        if (rd !== 32'hDEADBEEF) begin fail_cnt++; $display("FAIL word_rd_data got=%h want=deadbeef", rd); end
        @(negedge HCLK);
        cmp_cnt++;
        if (HRDATA !== 32'd0) begin fail_cnt++; $display("FAIL idle_hrdata got=%h want=0", HRDATA); end
        // Highest register, exercising the last index.
        xfer(32'h1C, 3'd2, 1'b1, 32'hCAFE0001, rd, nw, er);
        exp_regs[255:224] = 32'hCAFE0001;
        xfer(32'h1C, 3'd2, 1'b0, 32'h0, rd, nw, er);
        cmp_cnt++;
        if (rd !== 32'hCAFE0001 || nw != EXP_WAIT) begin fail_cnt++; $display("FAIL top_reg_rd got=%h/%0d want=cafe0001/%0d", rd, nw, EXP_WAIT); end
    endtask

    task automatic test_sub_word();
        logic [31:0] rd;
        int          nw;
        logic        er;
        xfer(32'h08, 3'd2, 1'b1, 32'h11223344, rd, nw, er);
        xfer(32'h0B, 3'd0, 1'b1, 32'hAA000000, rd, nw, er);
        exp_regs[95:64] = 32'hAA223344;
        xfer(32'h0E, 3'd1, 1'b1, 32'hBEEF5555, rd, nw, er);
        exp_regs[127:96] = 32'hBEEF0000;
        xfer(32'h08, 3'd2, 1'b0, 32'h0, rd, nw, er);
        cmp_cnt++;
        if (rd !== 32'hAA223344) begin fail_cnt++; $display("FAIL byte_write got=%h want=aa223344", rd); end
        cmp_cnt++;
        if (REG_Q[127:96] !== 32'hBEEF0000) begin fail_cnt++; $display("FAIL half_write got=%h want=beef0000", REG_Q[127:96]); end
        xfer(32'h09, 3'd0, 1'b1, 32'h00007700, rd, nw, er);
        exp_regs[95:64] = 32'hAA227744;
        @(negedge HCLK);
        cmp_cnt++;
        if (REG_Q !== exp_regs) begin fail_cnt++; $display("FAIL byte_lane1 got=%h want=%h", REG_Q[95:64], exp_regs[95:64]); end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        int          nw;
        logic        er;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HSIZE = 3'd2; HWRITE = 1'b0;
        @(negedge HCLK);
        bus_idle();
        cmp_cnt++;
        if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin fail_cnt++; $display("FAIL err1 got=%b%b want=01", HREADYOUT, HRESP); end
        @(negedge HCLK);
        cmp_cnt++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || HRDATA !== 32'd0) begin
            fail_cnt++; $display("FAIL err2 got=%b%b/%h want=11/0", HREADYOUT, HRESP, HRDATA);
        end
        @(negedge HCLK);
        cmp_cnt++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin fail_cnt++; $display("FAIL err_exit got=%b%b want=10", HREADYOUT, HRESP); end
        xfer(32'h05, 3'd2, 1'b1, 32'hFFFFFFFF, rd, nw, er);
        cmp_cnt++;
        if (!er || nw != 1) begin fail_cnt++; $display("FAIL misalign_word got=err%b/%0d want=err1/1", er, nw); end
        xfer(32'h0D, 3'd1, 1'b1, 32'hFFFFFFFF, rd, nw, er);
        cmp_cnt++;
        if (!er || nw != 1) begin fail_cnt++; $display("FAIL misalign_half got=err%b/%0d want=err1/1", er, nw); end
        xfer(32'h00, 3'd3, 1'b1, 32'hFFFFFFFF, rd, nw, er);
        cmp_cnt++;
        if (!er || nw != 1) begin fail_cnt++; $display("FAIL bad_size got=err%b/%0d want=err1/1", er, nw); end
        xfer(32'h40, 3'd2, 1'b1, 32'hFFFFFFFF, rd, nw, er);
        @(negedge HCLK);
        cmp_cnt++;
        if (REG_Q !== exp_regs) begin fail_cnt++; $display("FAIL err_no_write got=%h want=%h", REG_Q, exp_regs); end
    endtask

    task automatic test_idle_busy();
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b1;
        @(negedge HCLK);
        HTRANS = 2'b00; HWDATA = 32'h12345678;
        cmp_cnt++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin fail_cnt++; $display("FAIL busy_resp got=%b%b want=10", HREADYOUT, HRESP); end
        @(negedge HCLK);
        bus_idle();
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        @(negedge HCLK);
        cmp_cnt++;
        if (REG_Q !== exp_regs) begin fail_cnt++; $display("FAIL no_xfer_write got=%h want=%h", REG_Q[31:0], exp_regs[31:0]); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h5;
        n = 0;
        while (HREADYOUT !== 1'b1 && n < 40) begin n++; @(negedge HCLK); end
        cmp_cnt++;
        if (n != EXP_WAIT) begin fail_cnt++; $display("FAIL b2b_wr_waits got=%0d want=%0d", n, EXP_WAIT); end
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b0;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h0;
        exp_regs[31:0] = 32'h5;
        n = 0;
        while (HREADYOUT !== 1'b1 && n < 40) begin n++; @(negedge HCLK); end
        cmp_cnt++;
        if (HRDATA !== 32'h5 || n != EXP_WAIT) begin fail_cnt++; $display("FAIL b2b_read got=%h/%0d want=5/%0d", HRDATA, n, EXP_WAIT); end
    endtask

    task automatic test_reset_mid();
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h10; HSIZE = 3'd2; HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h12345678;
        HRESETn = 1'b0;
        #1;
        exp_regs = '0;
        cmp_cnt++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin fail_cnt++; $display("FAIL midrst_resp got=%b%b want=10", HREADYOUT, HRESP); end
        cmp_cnt++;
        if (HRDATA !== 32'd0 || REG_Q !== 256'd0) begin fail_cnt++; $display("FAIL midrst_clear got=%h/%h want=0/0", HRDATA, REG_Q); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        cmp_cnt++;
        if (REG_Q[159:128] !== 32'd0 || HREADYOUT !== 1'b1) begin
            fail_cnt++; $display("FAIL midrst_discard got=%h/%b want=0/1", REG_Q[159:128], HREADYOUT);
        end
    endtask

    initial begin
        HRESETn  = 1'b0;
        HWDATA   = 32'd0;
        exp_regs = '0;
        bus_idle();
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        test_reset();
        test_word_rw();
        test_sub_word();
        test_error();
        test_idle_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
